// File: rtl/ppu_pkg.sv
// ppu_pkg: register indices, ctrl/mask bit positions and VRAM increment constants shared by the PPU CPU interface
package ppu_pkg;

   typedef enum logic [2:0] {
      PPUCTRL   = 3'd0,
      PPUMASK   = 3'd1,
      PPUSTATUS = 3'd2,
      OAMADDR   = 3'd3,
      OAMDATA   = 3'd4,
      PPUSCROLL = 3'd5,
      PPUADDR   = 3'd6,
      PPUDATA   = 3'd7
   } ppu_reg_e;

   localparam int CTRL_INC32    = 2;
   localparam int CTRL_NMI_EN   = 7;
   localparam int MASK_SHOW_BG  = 3;
   localparam int MASK_SHOW_SPR = 4;

   localparam logic [14:0] VINC_ACROSS  = 15'd1;
   localparam logic [14:0] VINC_DOWN    = 15'd32;
   localparam logic [5:0]  PALETTE_PAGE = 6'h3F;

endpackage

// File: rtl/ppu_loopy_regs.sv
// ppu_loopy_regs: t/v/fine_x scroll state and the shared first/second write toggle
module ppu_loopy_regs
   import ppu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        wr,
   input  logic        rd_stat,
   input  logic        inc_en,
   input  logic        inc32,
   input  logic [2:0]  address,
   input  logic [7:0]  wdata,
   output logic [14:0] t_addr,
   output logic [14:0] v_addr,
   output logic [2:0]  fine_x
);

   logic [14:0] t_q, t_d, v_q, v_d;
   logic [2:0]  fx_q, fx_d;
   logic        w_q, w_d;

   // scroll/address writes, status-read toggle clear and PPUDATA auto-increment
   always_comb begin
      t_d  = t_q;
      v_d  = v_q;
      fx_d = fx_q;
      w_d  = w_q;
      if (wr) begin
         case (address)
            PPUCTRL: t_d[11:10] = wdata[1:0];
            PPUSCROLL: begin
               if (!w_q) begin
                  fx_d     = wdata[2:0];
                  t_d[4:0] = wdata[7:3];
               end else begin
                  t_d[14:12] = wdata[2:0];
                  t_d[9:5]   = wdata[7:3];
               end
               w_d = ~w_q;
            end
            PPUADDR: begin
               if (!w_q) begin
                  t_d[13:8] = wdata[5:0];
                  t_d[14]   = 1'b0;
               end else begin
                  t_d[7:0] = wdata;
                  v_d      = t_d;
               end
               w_d = ~w_q;
            end
            default: ;
         endcase
      end
      if (rd_stat) w_d = 1'b0;
      if (inc_en) v_d = v_q + (inc32 ? VINC_DOWN : VINC_ACROSS);
   end

   // scroll state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         t_q  <= '0;
         v_q  <= '0;
         fx_q <= '0;
         w_q  <= 1'b0;
      end else begin
         t_q  <= t_d;
         v_q  <= v_d;
         fx_q <= fx_d;
         w_q  <= w_d;
      end
   end

   assign t_addr = t_q;
   assign v_addr = v_q;
   assign fine_x = fx_q;

endmodule

// File: rtl/ppu_cpu_regs.sv
// ppu_cpu_regs: CPU-facing PPU register file; define PPU_PALETTE_READ_BYPASS_EN for unbuffered palette reads
module ppu_cpu_regs
   import ppu_pkg::*;
#(
   parameter int VRAM_AW = 14,
   parameter int OAM_AW  = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [2:0]         address,
   input  logic               cs_n,
   input  logic               rw,
   input  logic [7:0]         wdata,
   output logic [7:0]         rdata,
   input  logic               vblank_set,
   input  logic               vblank_clr,
   input  logic               spr0_hit_set,
   input  logic               spr_ovf_set,
   output logic               nmi,
   output logic [OAM_AW-1:0]  oam_addr,
   output logic [7:0]         oam_wdata,
   output logic               oam_we,
   output logic [VRAM_AW-1:0] vram_addr,
   output logic [7:0]         vram_wdata,
   output logic               vram_we,
   output logic               vram_re,
   input  logic [7:0]         vram_rdata,
   output logic [7:0]         ctrl,
   output logic [7:0]         mask,
   output logic [14:0]        t_addr,
   output logic [14:0]        v_addr,
   output logic [2:0]         fine_x
);

   logic               cs_n_q;
   logic               acc, wr, rd, rd_stat, pd_acc, byp;
   logic [7:0]         rd_val;
   logic [7:0]         ctrl_q, ctrl_d, mask_q, mask_d;
   logic [OAM_AW-1:0]  oam_addr_q, oam_addr_d;
   logic [7:0]         oam_wdata_q, oam_wdata_d;
   logic               oam_we_q, oam_we_d;
   logic [VRAM_AW-1:0] vram_addr_q, vram_addr_d;
   logic [7:0]         vram_wdata_q, vram_wdata_d;
   logic               vram_we_q, vram_we_d, vram_re_q, vram_re_d;
   logic               fill_q, fill_d;
   logic [7:0]         read_buf_q, read_buf_d;
   logic [7:0]         rdata_q, rdata_d;
   logic [7:0]         last_wdata_q, last_wdata_d;
   logic               vblank_q, vblank_d, spr0_q, spr0_d, ovf_q, ovf_d;

   assign acc     = ~cs_n & cs_n_q;
   assign wr      = acc & rw;
   assign rd      = acc & ~rw;
   assign rd_stat = rd && address == PPUSTATUS;
   assign pd_acc  = acc && address == PPUDATA && !(vram_we_q || vram_re_q);

   ppu_loopy_regs u_loopy (
      .clk     (clk),
      .rst     (rst),
      .wr      (wr),
      .rd_stat (rd_stat),
      .inc_en  (pd_acc),
      .inc32   (ctrl_q[CTRL_INC32]),
      .address (address),
      .wdata   (wdata),
      .t_addr  (t_addr),
      .v_addr  (v_addr),
      .fine_x  (fine_x)
   );

`ifdef PPU_PALETTE_READ_BYPASS_EN
   logic pal_q, pal_d;
   // remember whether the outstanding PPUDATA read targets palette space
   always_comb pal_d = vram_re_d ? (v_addr[13:8] == PALETTE_PAGE) : pal_q;
   // palette flag register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) pal_q <= 1'b0;
      else     pal_q <= pal_d;
   end
   assign byp = fill_q & pal_q;
`else
   assign byp = 1'b0;
`endif

   // register decode, strobes, read buffer, status flags and read data
   always_comb begin
      ctrl_d       = (wr && address == PPUCTRL) ? wdata : ctrl_q;
      mask_d       = (wr && address == PPUMASK) ? wdata : mask_q;
      oam_addr_d   = (wr && address == OAMADDR) ? OAM_AW'(wdata) :
                     oam_we_q ? oam_addr_q + OAM_AW'(1) : oam_addr_q;
      oam_we_d     = wr && address == OAMDATA;
      oam_wdata_d  = oam_we_d ? wdata : oam_wdata_q;
      vram_we_d    = pd_acc & rw;
      vram_re_d    = pd_acc & ~rw;
      vram_addr_d  = pd_acc ? v_addr[VRAM_AW-1:0] : vram_addr_q;
      vram_wdata_d = vram_we_d ? wdata : vram_wdata_q;
      fill_d       = vram_re_q;
      read_buf_d   = fill_q ? vram_rdata : read_buf_q;
      last_wdata_d = wr ? wdata : last_wdata_q;
      vblank_d     = ~vblank_clr & ~rd_stat & (vblank_q | vblank_set);
      spr0_d       = ~vblank_clr & (spr0_q | spr0_hit_set);
      ovf_d        = ~vblank_clr & (ovf_q | spr_ovf_set);
      rd_val       = (address == PPUSTATUS) ? {vblank_q, spr0_q, ovf_q, last_wdata_q[4:0]} :
                     (address == OAMDATA)   ? 8'h00 :
                     (address == PPUDATA)   ? (fill_q ? vram_rdata : read_buf_q) : last_wdata_q;
      rdata_d      = (rd && (address != PPUDATA || pd_acc)) ? rd_val : byp ? vram_rdata : rdata_q;
   end

   // all CPU-visible state; reset also abandons any pending buffer fill
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cs_n_q       <= 1'b1;
         ctrl_q       <= '0;
         mask_q       <= '0;
         oam_addr_q   <= '0;
         oam_we_q     <= 1'b0;
         oam_wdata_q  <= '0;
         vram_addr_q  <= '0;
         vram_wdata_q <= '0;
         vram_we_q    <= 1'b0;
         vram_re_q    <= 1'b0;
         fill_q       <= 1'b0;
         read_buf_q   <= '0;
         last_wdata_q <= '0;
         rdata_q      <= '0;
         vblank_q     <= 1'b0;
         spr0_q       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         cs_n_q       <= cs_n;
         ctrl_q       <= ctrl_d;
         mask_q       <= mask_d;
         oam_addr_q   <= oam_addr_d;
         oam_we_q     <= oam_we_d;
         oam_wdata_q  <= oam_wdata_d;
         vram_addr_q  <= vram_addr_d;
         vram_wdata_q <= vram_wdata_d;
         vram_we_q    <= vram_we_d;
         vram_re_q    <= vram_re_d;
         fill_q       <= fill_d;
         read_buf_q   <= read_buf_d;
         last_wdata_q <= last_wdata_d;
         rdata_q      <= rdata_d;
         vblank_q     <= vblank_d;
         spr0_q       <= spr0_d;
         ovf_q        <= ovf_d;
      end
   end

   assign ctrl       = ctrl_q;
   assign mask       = mask_q;
   assign oam_addr   = oam_addr_q;
   assign oam_we     = oam_we_q;
   assign oam_wdata  = oam_wdata_q;
   assign vram_addr  = vram_addr_q;
   assign vram_wdata = vram_wdata_q;
   assign vram_we    = vram_we_q;
   assign vram_re    = vram_re_q;
   assign rdata      = rdata_q;
   assign nmi        = vblank_q & ctrl_q[CTRL_NMI_EN];

endmodule

// File: tb/tb_ppu_cpu_regs.sv
// tb_ppu_cpu_regs: directed and random register accesses checked against a behavioural PPU register model
module tb_ppu_cpu_regs;
  logic        clk = 1'b0, rst = 1'b1;
  logic [2:0]  address = '0;
  logic        cs_n = 1'b1, rw = 1'b0;
  logic [7:0]  wdata = '0, rdata;
  logic        vblank_set = 1'b0, vblank_clr = 1'b0, spr0_hit_set = 1'b0, spr_ovf_set = 1'b0;
  logic        nmi, oam_we, vram_we, vram_re;
  logic [7:0]  oam_addr, oam_wdata, vram_wdata, ctrl, mask;
  logic [7:0]  vram_rdata = '0;
  logic [13:0] vram_addr;
  logic [14:0] t_addr, v_addr;
  logic [2:0]  fine_x;
  int vec = 0, errs = 0;
  logic [7:0] vram [0:16383];
  logic [7:0] ref_vram [0:16383];
  logic [7:0]  m_ctrl, m_mask, m_oam, m_last, m_buf, m_rdata;
  logic [14:0] m_t, m_v;
  logic [2:0]  m_fx;
  logic        m_w, m_vbl, m_spr0, m_ovf;
  ppu_cpu_regs dut (
    .clk(clk), .rst(rst), .address(address), .cs_n(cs_n), .rw(rw), .wdata(wdata), .rdata(rdata),
    .vblank_set(vblank_set), .vblank_clr(vblank_clr), .spr0_hit_set(spr0_hit_set),
    .spr_ovf_set(spr_ovf_set), .nmi(nmi), .oam_addr(oam_addr), .oam_wdata(oam_wdata),
    .oam_we(oam_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata), .vram_we(vram_we),
    .vram_re(vram_re), .vram_rdata(vram_rdata), .ctrl(ctrl), .mask(mask),
    .t_addr(t_addr), .v_addr(v_addr), .fine_x(fine_x)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (vram_we) vram[vram_addr] <= vram_wdata;
    if (vram_re) vram_rdata <= vram[vram_addr];
  end
  initial begin
    #5000000;
    errs++;
    $error("FAIL watchdog expired waiting for test completion");
    $finish;
  end
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vec++;
    if (o !== e) begin
      errs++;
      $error("FAIL %s obs=%0h exp=%0h", tag, o, e);
    end
  endtask
  task automatic model_reset();
    m_ctrl = 0; m_mask = 0; m_oam = 0; m_last = 0; m_buf = 0; m_rdata = 0;
    m_t = 0; m_v = 0; m_fx = 0; m_w = 0; m_vbl = 0; m_spr0 = 0; m_ovf = 0;
  endtask
  task automatic chk_zero(input string tag);
    chk(tag, {ctrl, mask, oam_addr, oam_wdata, vram_wdata, rdata}, 48'h0);
    chk(tag, {t_addr, v_addr, fine_x, vram_addr}, 47'h0);
    chk(tag, {nmi, oam_we, vram_we, vram_re}, 4'h0);
  endtask
  task automatic chk_state();
    chk("ctrl", ctrl, m_ctrl);
    chk("mask", mask, m_mask);
    chk("t_addr", t_addr, m_t);
    chk("v_addr", v_addr, m_v);
    chk("fine_x", fine_x, m_fx);
    chk("nmi", nmi, m_vbl & m_ctrl[7]);
    chk("rdata", rdata, m_rdata);
  endtask
  task automatic acc(input logic [2:0] a, input logic w, input logic [7:0] d, input logic vs);
    logic eow, evw, evr, stat;
    logic [7:0] eoa;
    logic [13:0] eva;
    logic [14:0] inc;
    address = a; rw = w; wdata = d; vblank_set = vs; cs_n = 1'b0;
    @(posedge clk); #1;
    cs_n = 1'b1; vblank_set = 1'b0;
    inc = m_ctrl[2] ? 15'd32 : 15'd1;
    eow = 0; evw = 0; evr = 0; stat = 0; eoa = m_oam; eva = m_v[13:0];
    if (w) begin
      m_last = d;
      case (a)
        3'd0: begin m_ctrl = d; m_t[11:10] = d[1:0]; end
        3'd1: m_mask = d;
        3'd3: begin m_oam = d; eoa = d; end
        3'd4: eow = 1;
        3'd5: begin
          if (!m_w) begin m_fx = d[2:0]; m_t[4:0] = d[7:3]; end
          else begin m_t[14:12] = d[2:0]; m_t[9:5] = d[7:3]; end
          m_w = ~m_w;
        end
        3'd6: begin
          if (!m_w) m_t = {1'b0, d[5:0], m_t[7:0]};
          else begin m_t[7:0] = d; m_v = m_t; end
          m_w = ~m_w;
        end
        3'd7: begin evw = 1; ref_vram[eva] = d; m_v = m_v + inc; end
        default: ;
      endcase
    end else begin
      case (a)
        3'd2: begin m_rdata = {m_vbl, m_spr0, m_ovf, m_last[4:0]}; m_vbl = 0; m_w = 0; stat = 1; end
        3'd4: m_rdata = 8'h00;
        3'd7: begin evr = 1; m_rdata = m_buf; m_buf = ref_vram[eva]; m_v = m_v + inc; end
        default: m_rdata = m_last;
      endcase
    end
    if (vs && !stat) m_vbl = 1;
    chk("oam_we", oam_we, eow);
    chk("oam_addr", oam_addr, eoa);
    if (eow) chk("oam_wdata", oam_wdata, d);
    chk("vram_we", vram_we, evw);
    chk("vram_re", vram_re, evr);
    if (evw || evr) chk("vram_addr", vram_addr, eva);
    if (evw) chk("vram_wdata", vram_wdata, d);
    chk_state();
    if (eow) m_oam = m_oam + 8'd1;
    @(posedge clk); #1;
  endtask
  task automatic pulse(input logic vs, input logic vc, input logic s0, input logic ov);
    vblank_set = vs; vblank_clr = vc; spr0_hit_set = s0; spr_ovf_set = ov;
    @(posedge clk); #1;
    vblank_set = 0; vblank_clr = 0; spr0_hit_set = 0; spr_ovf_set = 0;
    m_vbl  = !vc && (m_vbl || vs);
    m_spr0 = !vc && (m_spr0 || s0);
    m_ovf  = !vc && (m_ovf || ov);
    chk("nmi_pulse", nmi, m_vbl & m_ctrl[7]);
  endtask
  initial begin
    int n;
    logic [7:0] x;
    model_reset();
    for (int i = 0; i < 16384; i++) begin
      x = 8'($urandom);
      vram[i] = x;
      ref_vram[i] = x;
    end
    repeat (2) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    @(posedge clk); #1;
    acc(3'd5, 1, 8'h7D, 0);
    acc(3'd5, 1, 8'h5E, 0);
    chk("plan_t", t_addr, 15'h616F);
    chk("plan_fx", fine_x, 3'd5);
    acc(3'd6, 1, 8'h3F, 0);
    acc(3'd6, 1, 8'h10, 0);
    acc(3'd7, 1, 8'h21, 0);
    chk("plan_v3f11", v_addr, 15'h3F11);
    acc(3'd0, 1, 8'h04, 0);
    acc(3'd6, 1, 8'h20, 0);
    acc(3'd6, 1, 8'h00, 0);
    vram[14'h2000] = 8'hAB;
    ref_vram[14'h2000] = 8'hAB;
    acc(3'd7, 0, 8'h00, 0);
    chk("plan_rd1", rdata, 8'h00);
    acc(3'd7, 0, 8'h00, 0);
    chk("plan_rd2", rdata, 8'hAB);
    chk("plan_v2040", v_addr, 15'h2040);
    acc(3'd3, 1, 8'hFF, 0);
    acc(3'd4, 1, 8'h12, 0);
    chk("plan_oam_wrap", oam_addr, 8'h00);
    acc(3'd0, 1, 8'h80, 0);
    pulse(1, 0, 0, 0);
    chk("plan_nmi_on", nmi, 1'b1);
    acc(3'd2, 0, 8'h00, 0);
    chk("plan_stat_b7", rdata[7], 1'b1);
    chk("plan_nmi_off", nmi, 1'b0);
    acc(3'd2, 0, 8'h00, 1);
    chk("plan_race_b7", rdata[7], 1'b0);
    chk("plan_race_nmi", nmi, 1'b0);
    acc(3'd0, 1, 8'h00, 0);
    pulse(1, 0, 1, 1);
    acc(3'd0, 1, 8'h80, 0);
    chk("plan_nmi_reenable", nmi, 1'b1);
    pulse(0, 1, 0, 0);
    address = 3'd7; rw = 1; wdata = 8'h5A; cs_n = 0; n = 0;
    repeat (4) begin @(posedge clk); #1; n += int'(vram_we); end
    cs_n = 1;
    @(posedge clk); #1;
    n += int'(vram_we);
    ref_vram[m_v[13:0]] = 8'h5A; m_last = 8'h5A; m_v = m_v + (m_ctrl[2] ? 15'd32 : 15'd1);
    chk("hold_we_count", n, 1);
    chk_state();
    address = 3'd7; rw = 0; cs_n = 0;
    @(posedge clk); #1;
    chk("mid_re", vram_re, 1'b1);
    rst = 1'b1; #1;
    chk_zero("mid_rst_async");
    cs_n = 1;
    @(posedge clk); #1;
    chk_zero("mid_rst_cycle");
    rst = 1'b0;
    model_reset();
    @(posedge clk); #1;
    acc(3'd7, 0, 8'h00, 0);
    chk("post_rst_buf", rdata, 8'h00);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) == 0)
        pulse(1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else
        acc(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 7) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/ppu_cpu_regs.md
# ppu_cpu_regs

CPU-facing register file of the PPU. It decodes single-cycle register accesses on the 3-bit PPU bus ($2000–$2007 mirror index), including those issued by the NMI-driven sprite/scroll driver. It holds the scroll/address latch state, generates OAM and VRAM access strobes, and drives the level NMI output that the driver edge-detects. It sits between the CPU bus and the PPU render/OAM/VRAM back end.

## Interface
Parameters:
- VRAM_AW, 14, VRAM address width; addresses are masked to this width.
- OAM_AW, 8, OAM byte address width.

Ports:
- clk  in  1  PPU-side bus clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- address  in  3  register index 0–7
- cs_n  in  1  chip select, active low
- rw  in  1  1 = write, 0 = read
- wdata  in  8  CPU write data
- rdata  out  8  CPU read data
- vblank_set  in  1  one-cycle pulse at vblank start
- vblank_clr  in  1  one-cycle pulse at pre-render line (clears vblank, sprite0, overflow)
- spr0_hit_set, spr_ovf_set  in  1  status set pulses from renderer
- nmi  out  1  level: vblank_flag & ctrl[7]
- oam_addr  out  OAM_AW  current OAMADDR
- oam_wdata  out  8, oam_we  out  1  OAM write port
- vram_addr  out  VRAM_AW, vram_wdata  out  8, vram_we  out  1, vram_re  out  1  VRAM port
- vram_rdata  in  8  valid one cycle after vram_re
- ctrl, mask  out  8  PPUCTRL/PPUMASK
- t_addr, v_addr  out  15, fine_x  out  3  scroll state for renderer

## Operation
- Access event = cycle with cs_n=0 and cs_n=1 on the previous cycle; held-low cs_n produces exactly one access.
- Writes: 0 → ctrl, t[11:10]=d[1:0]. 1 → mask. 3 → oam_addr. 4 → oam_we pulse with oam_wdata=d at oam_addr; oam_addr+1 next cycle (mod 256). 5 → w=0: fine_x=d[2:0], t[4:0]=d[7:3], w=1; w=1: t[14:12]=d[2:0], t[9:5]=d[7:3], w=0. 6 → w=0: t[13:8]=d[5:0], t[14]=0, w=1; w=1: t[7:0]=d, v=t(new), w=0. 7 → vram_we pulse at v, v += ctrl[2]?32:1 (15-bit wrap). Write to 2 ignored.
- Reads: 2 → {vblank, spr0, ovf, last_wdata[4:0]}; clears vblank flag and w. 4 → OAM byte via oam_wdata-path is not supported; returns 8'h00. 7 → returns read_buf, pulses vram_re at v, captures vram_rdata into read_buf next cycle, increments v. Others return last_wdata.
- Status: vblank set on vblank_set, cleared on vblank_clr or status read; spr0/ovf set by pulses, cleared by vblank_clr.
- Status read in same cycle as vblank_set: read returns bit7=0 and flag stays clear (NMI suppressed that frame).
- Writing ctrl[7] 0→1 while vblank=1 produces a new nmi rising edge.

## Timing
- Reset: ctrl, mask, oam_addr, t, v, fine_x, w, read_buf, flags = 0; nmi, oam_we, vram_we, vram_re = 0; rdata = 0.
- Register writes visible on outputs the cycle after the access.
- rdata registered: valid the cycle after the access, held until next read access.
- Strobes (oam_we, vram_we, vram_re) are one cycle wide, asserted the cycle after the access.
- A new PPUDATA access may arrive no sooner than 2 cycles after the previous one; earlier accesses are dropped.
- rst mid-access aborts pending buffer fill; read_buf stays 0.

## Configuration
- PPU_PALETTE_READ_BYPASS_EN: when defined, PPUDATA reads with v[13:8]=6'h3F return vram_rdata directly (rdata valid 2 cycles after access) while still filling read_buf. When undefined, all PPUDATA reads are buffered.

## Structure
- Shared package ppu_pkg: register index enum (PPUCTRL…PPUDATA), ctrl/mask bit-position constants, VRAM address-increment constants.
- One sub-module ppu_loopy_regs: t/v/fine_x/w update logic. The parent keeps decode, status, OAM and buffer logic.

## Test plan
- Write 5 with 8'h7D, then 8'h5E → fine_x=5, t=15'h616F, w=0.
- Write 6 with 8'h3F, then 8'h10; write 7 with 8'h21 → vram_we at 14'h3F10 with data 8'h21; v=15'h3F11 (ctrl[2]=0).
- Set ctrl[2]=1; PPUDATA read at v=15'h2000 with vram_rdata=8'hAB → first rdata=8'h00, second read rdata=8'hAB, v=15'h2040.
- Write 3 with 8'hFF, then 4 with 8'h12 → oam_we at 8'hFF, oam_addr wraps to 8'h00.
- vblank_set with ctrl[7]=1 → nmi=1; status read → rdata[7]=1, nmi=0; status read coincident with vblank_set → rdata[7]=0, nmi stays 0.
- cs_n held low 4 cycles on write 7 → exactly one vram_we; assert rst mid-sequence → all outputs 0 next cycle.
